// File: rtl/addsub_byte_seq_if.sv
// Handshake and operand/result bundle for addsub_byte_seq.
// Optional macro ZERO_FLAG_EN adds the registered zero flag to the bundle.
interface addsub_byte_seq_if #(
  parameter int unsigned NBYTES = 4
);
  logic                  start;
  logic                  sel;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   result;
  logic                  cout;
  logic                  overflow;
`ifdef ZERO_FLAG_EN
  logic                  zero;
`endif

`ifdef ZERO_FLAG_EN
  modport master (
    output start, sel, a, b,
    input  busy, done, result, cout, overflow, zero
  );
  modport slave (
    input  start, sel, a, b,
    output busy, done, result, cout, overflow, zero
  );
`else
  modport master (
    output start, sel, a, b,
    input  busy, done, result, cout, overflow
  );
  modport slave (
    input  start, sel, a, b,
    output busy, done, result, cout, overflow
  );
`endif
endinterface

// File: rtl/addsub_byte_seq.sv
// Byte-serial wide adder/subtractor: one shared 8-bit add/sub slice is
// stepped across an NBYTES-wide operand, LSB byte first, one byte per clock.
// Optional macro ZERO_FLAG_EN adds a registered zero flag derived from a
// sticky "any nonzero byte" bit.
module addsub_byte_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  addsub_byte_seq_if.slave      bus
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_nx;

  logic [8*NBYTES-1:0]   a_q;
  logic [8*NBYTES-1:0]   b_q;
  logic                  sel_q;
  logic [IW-1:0]         idx;
  logic                  carry;
  logic [8*NBYTES-1:0]   result_q;
  logic                  cout_q;
  logic                  ovf_q;
`ifdef ZERO_FLAG_EN
  logic                  nz_q;
  logic                  zero_q;
`endif

  logic                  accept;
  logic                  last;
  logic [7:0]            a_byte;
  logic [7:0]            b_byte;
  logic [8:0]            s;
  logic                  c7;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (idx == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    begin bus.busy = 1'b1; bus.done = 1'b1; end
      default: ;
    endcase
  end

  // Shared byte slice: subtraction inverts b and relies on carry-in = sel
  always_comb begin
    accept = (state == IDLE) && bus.start;
    last   = (idx == LAST);
    a_byte = a_q[idx*8 +: 8];
    b_byte = b_q[idx*8 +: 8] ^ {8{sel_q}};
    s      = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry};
    // carry into bit 7 recovered from the sum bit and its two inputs
    c7     = a_byte[7] ^ b_byte[7] ^ s[7];
  end

  // Operand latch, byte sequencing and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ZERO_FLAG_EN
      nz_q     <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      sel_q    <= bus.sel;
      idx      <= '0;
      carry    <= bus.sel;
`ifdef ZERO_FLAG_EN
      nz_q     <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else if (state == RUN) begin
      result_q[idx*8 +: 8] <= s[7:0];
      carry    <= s[8];
      idx      <= idx + 1'b1;
`ifdef ZERO_FLAG_EN
      nz_q     <= nz_q | (s[7:0] != 8'h00);
`endif
      if (last) begin
        cout_q <= s[8];
        ovf_q  <= c7 ^ s[8];
`ifdef ZERO_FLAG_EN
        // the sticky bit does not yet include this byte, so fold it in here
        zero_q <= ~(nz_q | (s[7:0] != 8'h00));
`endif
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
`ifdef ZERO_FLAG_EN
  assign bus.zero     = zero_q;
`endif

endmodule

// File: tb/tb_addsub_byte_seq.sv
// Directed self-checking bench for addsub_byte_seq with NBYTES=4.
// Zero-flag checks are compiled in when ZERO_FLAG_EN is defined.
module tb_addsub_byte_seq;

  localparam int unsigned NB = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  addsub_byte_seq_if #(.NBYTES(NB)) bus ();

  addsub_byte_seq #(.NBYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion, checking timing and results.
  task automatic run_op(input string tag, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] er,
                        input logic ec, input logic eo, input logic ez);
    int busy_cnt;
    int done_cnt;
    int done_at;
    bit seen_busy;
    busy_cnt  = 0;
    done_cnt  = 0;
    done_at   = -1;
    seen_busy = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = s;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.busy) begin
        busy_cnt++;
        seen_busy = 1;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (seen_busy && !bus.busy) break;
    end
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd5);
    check({tag, ".done_at"},     64'(done_at),  64'd4);
    check({tag, ".done_count"},  64'(done_cnt), 64'd1);
    check({tag, ".result"},      64'(bus.result), 64'(er));
    check({tag, ".cout"},        64'(bus.cout),   64'(ec));
    check({tag, ".overflow"},    64'(bus.overflow), 64'(eo));
`ifdef ZERO_FLAG_EN
    check({tag, ".zero"},        64'(bus.zero),   64'(ez));
`else
    if (ez) ;
`endif
  endtask

  initial begin
    int done_cnt;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sel   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.busy",     64'(bus.busy), 64'd0);
    check("rst.done",     64'(bus.done), 64'd0);
    check("rst.result",   64'(bus.result), 64'd0);
    check("rst.cout",     64'(bus.cout), 64'd0);
    check("rst.overflow", 64'(bus.overflow), 64'd0);
`ifdef ZERO_FLAG_EN
    check("rst.zero",     64'(bus.zero), 64'd0);
`endif
    rst = 1'b0;

    run_op("add_carry",  1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_op("sub_borrow", 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf",    1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf",    1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("add_wrap",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Hold start high and disturb operands while the operation runs.
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = 1'b0;
    bus.a     = 32'h0000_0010;
    bus.b     = 32'h0000_0020;
    done_cnt  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.a   = 32'hFFFF_FFFF;
        bus.b   = 32'h1234_5678;
        bus.sel = 1'b1;
      end
      if (bus.done) begin
        done_cnt++;
        bus.start = 1'b0;
      end
    end
    check("hold.done_count", 64'(done_cnt), 64'd1);
    check("hold.result",     64'(bus.result), 64'h0000_0030);
    check("hold.cout",       64'(bus.cout), 64'd0);
    check("hold.busy_after", 64'(bus.busy), 64'd0);

    // Reset during the byte-2 cycle, with start also asserted alongside rst.
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = 1'b0;
    bus.a     = 32'h1111_1111;
    bus.b     = 32'h2222_2222;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid.partial", 64'(bus.result[7:0]), 64'h33);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check("mid.busy",     64'(bus.busy), 64'd0);
    check("mid.done",     64'(bus.done), 64'd0);
    check("mid.result",   64'(bus.result), 64'd0);
    check("mid.cout",     64'(bus.cout), 64'd0);
    check("mid.overflow", 64'(bus.overflow), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("mid.no_accept", 64'(bus.busy), 64'd0);

    run_op("post_rst", 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/addsub_byte_seq.md
Name: addsub_byte_seq

Overview:
- Multi-cycle controller that sequences one shared 8-bit add/sub slice across an NBYTES-wide operand, one byte per clock, LSB byte first.
- Builds wide adders and subtractors (32-bit default) from the team's 8-bit adder/subtractor datapath without replicating it.
- Start/busy/done handshake; result, carry-out and signed overflow are registered and held until the next operation.

Parameters:
- NBYTES, 4, number of byte slices in each operand; legal range 2..16.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sel  input  1  operation: 0 = a + b, 1 = a - b.
- a  input  8*NBYTES  operand A; latched when start is accepted.
- b  input  8*NBYTES  operand B; latched when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is complete.
- result  output  8*NBYTES  registered sum or difference.
- cout  output  1  carry out of the MSB byte; for subtraction, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset: only synchronous rst, active-high. State=IDLE. busy=0, done=0, result=0, cout=0, overflow=0. Internal byte index and carry are cleared.
- States and transitions:
  - IDLE: start=1 at an edge moves to RUN. The same edge latches a, b and sel, sets idx=0 and carry=sel.
  - RUN: each edge processes byte idx. The byte sum is s = a_byte + (b_byte XOR {8{sel}}) + carry, 9 bits wide. result byte idx <= s[7:0], carry <= s[8], idx <= idx+1.
  - RUN, last byte (idx = NBYTES-1): cout <= s[8]. overflow <= carry into bit 7 XOR s[8]. done <= 1. Next state is DONE.
  - DONE: one cycle only. Next edge clears done and returns to IDLE.
- Subtraction is a + ~b + 1. The +1 comes from the initial carry=sel; no separate negation stage.
- Latency: start accepted at edge E0, done high during the cycle after edge E_NBYTES. That is NBYTES cycles from accept to done, and NBYTES+1 cycles of busy.
- Throughput: a new start is accepted in the first cycle after DONE, one operation per NBYTES+2 cycles.
- start while busy=1 (RUN or DONE) is ignored. It is not queued.
- Changes on a, b or sel after accept have no effect on the operation in flight.
- result, cout and overflow may change byte-by-byte during RUN. They are valid when done=1 and hold their values in IDLE until the next accept.
- rst mid-operation: takes priority over everything. It aborts the operation, returns all outputs to reset values and discards the latched operands.
- rst and start in the same cycle: rst wins; start is not accepted.
- Carry wraps: an all-ones + 1 result is 0 with cout=1. No saturation.

Optional Feature:
- Macro ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit), registered.
  - Cleared to 0 on reset.
  - Cleared to 0 on accept.
  - Set at the last-byte edge to 1 only if every result byte computed in this operation is 0x00.
  - Held with result.
  - Tracking uses a sticky "any nonzero byte" bit updated each RUN cycle; no wide NOR over result.
- Undefined: no zero port and no tracking logic. All other behaviour is identical.

Test Plan (NBYTES=4):
- sel=0, a=0x000000FF, b=0x00000001, start for 1 cycle -> busy 5 cycles; done pulses exactly 4 cycles after accept; result=0x00000100, cout=0, overflow=0.
- sel=1, a=0x00000005, b=0x00000007 -> result=0xFFFFFFFE, cout=0 (borrow), overflow=0.
- sel=0, a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, cout=0, overflow=1.
- sel=1, a=0x80000000, b=0x00000001 -> result=0x7FFFFFFF, cout=1, overflow=1.
- sel=0, a=0xFFFFFFFF, b=0x00000001 -> result=0x00000000, cout=1, overflow=0; with ZERO_FLAG_EN, zero=1.
- Ignored start and mid-operation reset:
  - Hold start high and change a/b during RUN -> only one done pulse; result matches the operands latched at accept.
  - Assert rst during the byte-2 cycle -> next cycle busy=0, done=0, result=0.
  - A following start with a=1, b=2, sel=0 -> result=0x00000003.
